amp_ratio_engine: RTL

Multi-channel fixed-point amplitude-ratio engine. Per sample it computes |I|/|Q| in Q-format with an iterative divider, scales the result by a per-channel programmable gain, and returns a saturated signed or absolute value. Low-level and divide-by-zero samples are flagged, not silently dropped. It sits between the I/Q demodulator and the output formatter, with valid/ready handshakes on both sides.

---
 rtl/arith_pkg.sv | 33 +++
 rtl/seq_divider.sv | 79 +++++++
 rtl/amp_ratio_engine.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the amplitude-ratio datapath: FSM states, flag bit
// positions, config address map and the saturation limit helper.
package arith_pkg;

  localparam int W_DEF     = 16;
  localparam int FRAC_DEF  = 16;
  localparam int CH_DEF    = 4;
  localparam int OUT_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ABS  = 3'd1,
    ST_DIV  = 3'd2,
    ST_GAIN = 3'd3,
    ST_SAT  = 3'd4,
    ST_OUT  = 3'd5
  } state_e;

  localparam int FLG_LOW  = 0;
  localparam int FLG_DIV0 = 1;
  localparam int FLG_SAT  = 2;

  // Address map assumes the default channel count.
  localparam int GAIN_BASE = 0;
  localparam int THR_BASE  = CH_DEF;
  localparam int MODE_ADDR = 2 * CH_DEF;

  // Largest positive value of a signed out_w-bit result.
  function automatic logic [63:0] sat_max(input int out_w);
    return (64'd1 << (out_w - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per enabled cycle.
// The start cycle already performs the first step, so the quotient is ready
// DVD_W enabled edges after start; done flags the edge of the final step.
module seq_divider #(
  parameter int DVD_W = 32,
  parameter int DVS_W = 16
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             en,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient
);
  localparam int CW = $clog2(DVD_W + 1);

  logic [DVD_W-1:0] quo_q, quo_d, src_quo;
  logic [DVS_W-1:0] rem_q, rem_d, dvs_q, dvs_d, src_rem, src_dvs, rem_step;
  logic [DVS_W:0]   trial;
  logic             ge;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;

  // One restoring step on either fresh operands (start) or the running state
  always_comb begin
    src_quo  = start ? dividend : quo_q;
    src_rem  = start ? '0 : rem_q;
    src_dvs  = start ? divisor : dvs_q;
    trial    = {src_rem, src_quo[DVD_W-1]};
    ge       = (trial >= {1'b0, src_dvs});
    rem_step = ge ? DVS_W'(trial - {1'b0, src_dvs}) : trial[DVS_W-1:0];
  end

  // Load on start, then shift in one quotient bit per enabled cycle
  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (en && (start || busy_q)) begin
      quo_d = {src_quo[DVD_W-2:0], ge};
      rem_d = rem_step;
      if (start) begin
        dvs_d  = divisor;
        cnt_d  = CW'(DVD_W - 1);
        busy_d = 1'b1;
      end else begin
        cnt_d  = cnt_q - CW'(1);
        busy_d = (cnt_q != CW'(1));
      end
    end
  end

  // Divider state registers
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = en && busy_q && !start && (cnt_q == CW'(1));
  assign quotient = quo_q;

endmodule

// File: rtl/amp_ratio_engine.sv
// Per-channel |I|/|Q| ratio engine: abs, iterative divide, gain, saturate.
//   state | meaning
//   IDLE  | ready for a sample; captures sample and config snapshot
//   ABS   | magnitudes formed; low-level / divide-by-zero bypass decided
//   DIV   | restoring division, one quotient bit per cycle
//   GAIN  | ratio times snapshotted gain, truncated by FRAC
//   SAT   | clamp to +-MAX and apply sign in signed mode
//   OUT   | result presented until downstream accepts
module amp_ratio_engine
  import arith_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int CH    = CH_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int AW    = $clog2(2 * CH + 1),
  parameter int CHW   = $clog2(CH)
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             clk_en,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [31:0]      cfg_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CHW-1:0]   in_ch,
  input  logic [W-1:0]     i,
  input  logic [W-1:0]     q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [CHW-1:0]   out_ch,
  output logic [2:0]       out_flags
);
  localparam int DW = W + FRAC;
  localparam int PW = DW + 32;
  localparam int MW = PW - FRAC;
  localparam logic [63:0]      MAXV     = sat_max(OUT_W);
  localparam logic [OUT_W-1:0] POS_MAX  = MAXV[OUT_W-1:0];
  localparam logic [OUT_W-1:0] NEG_MAX  = OUT_W'(0) - POS_MAX;
  localparam logic [31:0]      GAIN_ONE = 32'd1 << FRAC;

  state_e state_q, state_d;
  logic [31:0]      gain_q [CH];
  logic [31:0]      gain_d [CH];
  logic [W-1:0]     thr_q [CH];
  logic [W-1:0]     thr_d [CH];
  logic             mode_q, mode_d;
  logic [CHW-1:0]   ch_q, ch_d;
  logic [W-1:0]     i_q, i_d, q_q, q_d, ts_q, ts_d;
  logic [31:0]      gs_q, gs_d;
  logic             ms_q, ms_d, sign_q, sign_d;
  logic [MW-1:0]    mag_q, mag_d;
  logic [OUT_W-1:0] res_q, res_d, out_data_q, out_data_d, clamped;
  logic [2:0]       flg_q, flg_d, out_flags_q, out_flags_d;
  logic             out_valid_q, out_valid_d;
  logic [CHW-1:0]   out_ch_q, out_ch_d;
  logic [W-1:0]     abs_i, abs_q;
  logic [DW-1:0]    ratio;
  logic [PW-1:0]    prod;
  logic             low_lvl, q_zero, bypass, sat_hit, div_start, div_busy, div_done;

  assign abs_i   = i_q[W-1] ? (~i_q + W'(1)) : i_q;
  assign abs_q   = q_q[W-1] ? (~q_q + W'(1)) : q_q;
  assign low_lvl = (ts_q != '0) && (abs_q < ts_q);
  assign q_zero  = (q_q == '0);
  assign bypass  = low_lvl || q_zero;
  assign prod    = PW'(ratio) * PW'(gs_q);
  assign sat_hit = (64'(mag_q) > MAXV);
  assign clamped = sat_hit ? POS_MAX : mag_q[OUT_W-1:0];

  seq_divider #(.DVD_W(DW), .DVS_W(W)) u_div (
    .clk      (clk),
    .reset_l  (reset_l),
    .en       (clk_en),
    .start    (div_start),
    .dividend ({abs_i, {FRAC{1'b0}}}),
    .divisor  (abs_q),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (ratio)
  );

  // State register
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; everything holds while clk_en is low
  always_comb begin
    state_d = state_q;
    if (clk_en) begin
      case (state_q)
        ST_IDLE: if (in_valid) state_d = ST_ABS;
        ST_ABS:  state_d = bypass ? ST_OUT : ST_DIV;
        ST_DIV:  if (div_done || !div_busy) state_d = ST_GAIN;
        ST_GAIN: state_d = ST_SAT;
        ST_SAT:  state_d = ST_OUT;
        ST_OUT:  if (out_valid_q && out_ready) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Handshake and divider launch decoded from the current state
  always_comb begin
    in_ready  = clk_en && (state_q == ST_IDLE);
    div_start = clk_en && (state_q == ST_ABS) && !bypass;
  end

  // Config register file, sample/config capture and per-state datapath
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      gain_d[c] = gain_q[c];
      thr_d[c]  = thr_q[c];
    end
    mode_d      = mode_q;
    ch_d        = ch_q;
    i_d         = i_q;
    q_d         = q_q;
    gs_d        = gs_q;
    ts_d        = ts_q;
    ms_d        = ms_q;
    sign_d      = sign_q;
    mag_d       = mag_q;
    res_d       = res_q;
    flg_d       = flg_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_flags_d = out_flags_q;
    if (clk_en) begin
      if (cfg_we) begin
        for (int c = 0; c < CH; c++) begin
          if (cfg_addr == AW'(GAIN_BASE + c)) gain_d[c] = cfg_data;
          if (cfg_addr == AW'(THR_BASE + c))  thr_d[c]  = cfg_data[W-1:0];
        end
        if (cfg_addr == AW'(MODE_ADDR)) mode_d = cfg_data[0];
      end
      case (state_q)
        ST_IDLE: if (in_valid) begin
          ch_d = in_ch;
          i_d  = i;
          q_d  = q;
          gs_d = gain_q[in_ch];
          ts_d = thr_q[in_ch];
          ms_d = mode_q;
        end
        ST_ABS: begin
          sign_d = i_q[W-1] ^ q_q[W-1];
          flg_d  = '0;
          res_d  = '0;
          if (low_lvl) begin
            flg_d[FLG_LOW] = 1'b1;
          end else if (q_zero) begin
            flg_d[FLG_DIV0] = 1'b1;
            if (i_q == '0)               res_d = '0;
            else if (ms_q && i_q[W-1])   res_d = NEG_MAX;
            else                         res_d = POS_MAX;
          end
        end
        ST_GAIN: mag_d = MW'(prod >> FRAC);
        ST_SAT: begin
          flg_d          = '0;
          flg_d[FLG_SAT] = sat_hit;
          res_d          = (ms_q && sign_q) ? (OUT_W'(0) - clamped) : clamped;
        end
        ST_OUT: begin
          if (!out_valid_q) begin
            out_valid_d = 1'b1;
            out_data_d  = res_q;
            out_ch_d    = ch_q;
            out_flags_d = flg_q;
          end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_flags_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath, config and output registers
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      for (int c = 0; c < CH; c++) begin
        gain_q[c] <= GAIN_ONE;
        thr_q[c]  <= '0;
      end
      mode_q      <= 1'b0;
      ch_q        <= '0;
      i_q         <= '0;
      q_q         <= '0;
      gs_q        <= '0;
      ts_q        <= '0;
      ms_q        <= 1'b0;
      sign_q      <= 1'b0;
      mag_q       <= '0;
      res_q       <= '0;
      flg_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_flags_q <= '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        gain_q[c] <= gain_d[c];
        thr_q[c]  <= thr_d[c];
      end
      mode_q      <= mode_d;
      ch_q        <= ch_d;
      i_q         <= i_d;
      q_q         <= q_d;
      gs_q        <= gs_d;
      ts_q        <= ts_d;
      ms_q        <= ms_d;
      sign_q      <= sign_d;
      mag_q       <= mag_d;
      res_q       <= res_d;
      flg_q       <= flg_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_flags_q <= out_flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_flags = out_flags_q;

endmodule
